cp0_exc_unit: RTL and testbench
===============================

# cp0_exc_unit

Coprocessor-0 register file and precise-exception commit unit for the 5-stage MIPS core. It consumes the exception, ERET and CP0-write information that the pipeline registers carry into the MEM stage, maintains BadVAddr/Count/Compare/Status/Cause/EPC, and raises timer and external interrupts. On a commit event it produces the pipeline-wide flush and the PC redirect, acting as the responder to the exception information collected in IF through EX.

## Interface
- EXC_VECTOR, 32'hBFC0_0380: redirect target for every exception or interrupt.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- MEM_valid  in  1  the MEM stage holds a real instruction (not a bubble).
- MEM_Exception  in  1  the instruction in MEM carries an exception.
- MEM_ExcCode  in  5  exception code carried with it.
- MEM_isBD  in  1  the instruction in MEM sits in a branch delay slot.
- MEM_PC  in  32  PC of the instruction in MEM.
- badvaddr  in  32  faulting address from EX_MEM.
- MEM_eret_flush  in  1  the instruction in MEM is ERET.
- MEM_CP0WrEn  in  1  MTC0 write request.
- MEM_CP0Addr  in  8  {rd[4:0], sel[2:0]}.
- MEM_GPR_RT  in  32  MTC0 write data.
- ext_int  in  6  level-sensitive hardware interrupt lines.
- CP0Out  out  32  combinational read of the register addressed by MEM_CP0Addr; returns 0 for an unmapped address.
- flush  out  1  flushes IF_ID, ID_EX, EX_MEM and the MEM-stage writes this cycle.
- redirect_pc  out  32  next PC whenever `flush` is 1.
- EPC_out  out  32  current EPC.

## Operation
- Register map (MEM_CP0Addr):
  - 8'h40 BadVAddr: read-only.
  - 8'h48 Count
  - 8'h58 Compare
  - 8'h60 Status
  - 8'h68 Cause
  - 8'h70 EPC
- Status fields:
  - BEV[22] is constant 1.
  - IM[15:8], EXL[1] and IE[0] are writable.
  - All other bits read 0.
- Cause fields:
  - BD[31] and TI[30] are read-only.
  - IP[15:10] is hardware-driven: IP[15:10] = {ext_int[5] | TI, ext_int[4:0]}, registered every cycle.
  - IP[9:8] is software-writable.
  - ExcCode[6:2] is read-only.
- Reset values: Status = 32'h0040_0000; Cause, Count, Compare, EPC, BadVAddr all 0; internal tick = 0.
- Count:
  - `tick` toggles every cycle; Count increments when tick = 1 (once per 2 clocks).
  - Count wraps from 32'hFFFF_FFFF to 0.
- Timer interrupt: TI is set on the edge after Count == Compare holds with Compare ≠ 0. Any MTC0 to Compare clears TI.
- int_pending = IE & ~EXL & |(Cause[15:8] & Status[15:8]).
- Commit priority, evaluated only when MEM_valid = 1:
  1. Interrupt: int_pending, ExcCode = 0.
  2. Exception: MEM_Exception, ExcCode = MEM_ExcCode.
  3. ERET: MEM_eret_flush.
  4. Otherwise: the MTC0 write.
- Exception or interrupt commit:
  - flush = 1 and redirect_pc = EXC_VECTOR.
  - Next edge, when EXL = 0: EPC ← MEM_isBD ? MEM_PC − 4 : MEM_PC, and Cause.BD ← MEM_isBD.
  - Next edge, unconditionally: EXL ← 1 and Cause.ExcCode ← code.
  - BadVAddr ← badvaddr only when the code is 4 (AdEL) or 5 (AdES).
- ERET commit: flush = 1, redirect_pc = EPC, and EXL ← 0 on the next edge.
- MTC0 is suppressed in any cycle where flush = 1.
- When MEM_valid = 0: no commit and flush = 0. A pending interrupt waits for the next valid instruction.

## Timing
- flush, redirect_pc and CP0Out are combinational from the current inputs and state, with zero latency.
- All register updates take effect at the following rising edge.
- An MFC0 in the cycle after an MTC0 to the same register reads the new value.
- Simultaneous events:
  - MTC0 Count on an increment cycle: the written value wins.
  - MTC0 Compare while Count == Compare: the clear of TI wins.
  - Exception plus ERET: the exception wins.
- Reset asserted mid-operation forces all registers to their reset values immediately, asynchronously. flush stays 0 while rst = 0.

## Test plan
- Reset, then 10 cycles idle: Count = 5, Status = 32'h0040_0000, flush = 0 throughout.
- MEM_Exception = 1, MEM_ExcCode = 4, MEM_PC = 32'h8000_0104, MEM_isBD = 1, badvaddr = 32'h8000_0003:
  - Same cycle: flush = 1, redirect_pc = 32'hBFC0_0380.
  - Next cycle: EPC = 32'h8000_0100, BD = 1, ExcCode = 4, BadVAddr = 32'h8000_0003, EXL = 1.
- Nested exception with EXL = 1 at PC 32'h8000_0200: EPC is unchanged and ExcCode is updated. A following ERET gives redirect_pc = the old EPC, and EXL = 0 on the next edge.
- Timer interrupt:
  - Program Compare = 6 and Status = 32'h0040_8001, keep MEM_valid = 1.
  - TI and IP7 set after Count reaches 6; the next valid instruction gives flush = 1 with ExcCode = 0.
  - MTC0 Compare then clears TI.
- ext_int[0] asserted with IM2 = 1 and IE = 1, but MEM_valid = 0 for 3 cycles: no flush. The first cycle with MEM_valid = 1 commits the interrupt.
- MTC0 Count = 32'hFFFF_FFFF: Count wraps to 0 on the next increment. An MTC0 issued in the same cycle as an exception commit leaves the target register unchanged.

Source files
------------

// File: rtl/cp0_exc_unit.sv
// CP0 register file and precise-exception commit unit for the 5-stage MIPS core.
// Commits interrupts, exceptions, ERET and MTC0 from the MEM stage; drives flush and redirect.
module cp0_exc_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_valid,
  input  logic        MEM_Exception,
  input  logic [4:0]  MEM_ExcCode,
  input  logic        MEM_isBD,
  input  logic [31:0] MEM_PC,
  input  logic [31:0] badvaddr,
  input  logic        MEM_eret_flush,
  input  logic        MEM_CP0WrEn,
  input  logic [7:0]  MEM_CP0Addr,
  input  logic [31:0] MEM_GPR_RT,
  input  logic [5:0]  ext_int,
  output logic [31:0] CP0Out,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] EPC_out
);

  localparam logic [31:0] ExcVector    = 32'hBFC0_0380;
  localparam logic [7:0]  AddrBadVAddr = 8'h40;
  localparam logic [7:0]  AddrCount    = 8'h48;
  localparam logic [7:0]  AddrCompare  = 8'h58;
  localparam logic [7:0]  AddrStatus   = 8'h60;
  localparam logic [7:0]  AddrCause    = 8'h68;
  localparam logic [7:0]  AddrEpc      = 8'h70;
  localparam logic [4:0]  ExcAdEL      = 5'd4;
  localparam logic [4:0]  ExcAdES      = 5'd5;

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic        tick_q, tick_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exc_code_q, exc_code_d;

  logic [31:0] status_val, cause_val;
  logic        int_pending, exc_commit, eret_commit, flush_raw, cp0_we;
  logic [4:0]  commit_code;

  assign status_val = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_val  = {bd_q, ti_q, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exc_code_q, 2'b00};

  assign int_pending = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));
  assign exc_commit  = MEM_valid & (int_pending | MEM_Exception);
  assign eret_commit = MEM_valid & ~exc_commit & MEM_eret_flush;
  assign flush_raw   = exc_commit | eret_commit;
  assign commit_code = int_pending ? 5'd0 : MEM_ExcCode;
  assign cp0_we      = MEM_valid & MEM_CP0WrEn & ~flush_raw;

  // State is held in reset anyway; gating only the output keeps rst off the D paths.
  assign flush       = rst & flush_raw;
  assign redirect_pc = exc_commit ? ExcVector : epc_q;
  assign EPC_out     = epc_q;

  always_comb begin
    CP0Out = 32'd0;
    case (MEM_CP0Addr)
      AddrBadVAddr: CP0Out = badvaddr_q;
      AddrCount:    CP0Out = count_q;
      AddrCompare:  CP0Out = compare_q;
      AddrStatus:   CP0Out = status_val;
      AddrCause:    CP0Out = cause_val;
      AddrEpc:      CP0Out = epc_q;
      default:      CP0Out = 32'd0;
    endcase
  end

  always_comb begin
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    epc_d      = epc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    tick_d     = ~tick_q;
    count_d    = tick_q ? count_q + 32'd1 : count_q;
    ti_d       = ti_q | ((count_q == compare_q) && (compare_q != 32'd0));
    ip_hw_d    = {ext_int[5] | ti_q, ext_int[4:0]};

    if (exc_commit) begin
      // A nested exception keeps the original return point.
      if (!exl_q) begin
        epc_d = MEM_isBD ? MEM_PC - 32'd4 : MEM_PC;
        bd_d  = MEM_isBD;
      end
      exl_d      = 1'b1;
      exc_code_d = commit_code;
      if (commit_code == ExcAdEL || commit_code == ExcAdES) begin
        badvaddr_d = badvaddr;
      end
    end

    if (eret_commit) begin
      exl_d = 1'b0;
    end

    if (cp0_we) begin
      case (MEM_CP0Addr)
        AddrCount:   count_d = MEM_GPR_RT;
        AddrCompare: begin
          compare_d = MEM_GPR_RT;
          ti_d      = 1'b0;
        end
        AddrStatus:  begin
          im_d  = MEM_GPR_RT[15:8];
          exl_d = MEM_GPR_RT[1];
          ie_d  = MEM_GPR_RT[0];
        end
        AddrCause:   ip_sw_d = MEM_GPR_RT[9:8];
        AddrEpc:     epc_d   = MEM_GPR_RT;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      epc_q      <= 32'd0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      tick_q     <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      exc_code_q <= 5'd0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      epc_q      <= epc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      tick_q     <= tick_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exc_code_q <= exc_code_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed scenarios plus randomized traffic
// checked against a behavioural CP0 model.
module tb_cp0_exc_unit;

  localparam logic [31:0] ExcVector = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_valid, MEM_Exception, MEM_isBD, MEM_eret_flush, MEM_CP0WrEn;
  logic [4:0]  MEM_ExcCode;
  logic [31:0] MEM_PC, badvaddr, MEM_GPR_RT;
  logic [7:0]  MEM_CP0Addr;
  logic [5:0]  ext_int;
  logic [31:0] CP0Out, redirect_pc, EPC_out;
  logic        flush;

  int checks = 0;
  int errors = 0;

  cp0_exc_unit dut (
    .clk           (clk),
    .rst           (rst),
    .MEM_valid     (MEM_valid),
    .MEM_Exception (MEM_Exception),
    .MEM_ExcCode   (MEM_ExcCode),
    .MEM_isBD      (MEM_isBD),
    .MEM_PC        (MEM_PC),
    .badvaddr      (badvaddr),
    .MEM_eret_flush(MEM_eret_flush),
    .MEM_CP0WrEn   (MEM_CP0WrEn),
    .MEM_CP0Addr   (MEM_CP0Addr),
    .MEM_GPR_RT    (MEM_GPR_RT),
    .ext_int       (ext_int),
    .CP0Out        (CP0Out),
    .flush         (flush),
    .redirect_pc   (redirect_pc),
    .EPC_out       (EPC_out)
  );

  always #5 clk = ~clk;

  // Behavioural model of the architectural CP0 state.
  logic [31:0] m_count, m_compare, m_epc, m_badv;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti, m_tick;
  logic [5:0]  m_ip_hw;
  logic [1:0]  m_ip_sw;
  logic [4:0]  m_exc;

  function automatic logic [31:0] m_status();
    return {9'd0, 1'b1, 6'd0, m_im, 6'd0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip_hw, m_ip_sw, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h40:   return m_badv;
      8'h48:   return m_count;
      8'h58:   return m_compare;
      8'h60:   return m_status();
      8'h68:   return m_cause();
      8'h70:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_int_pending();
    if (!m_ie || m_exl) return 1'b0;
    return (({m_ip_hw, m_ip_sw} & m_im) != 8'd0);
  endfunction

  function automatic logic m_flush();
    return rst && MEM_valid && (m_int_pending() || MEM_Exception || MEM_eret_flush);
  endfunction

  function automatic logic [31:0] m_redirect();
    return (m_int_pending() || MEM_Exception) ? ExcVector : m_epc;
  endfunction

  task automatic model_reset();
    m_count = 0; m_compare = 0; m_epc = 0; m_badv = 0; m_im = 0; m_exl = 0; m_ie = 0;
    m_bd = 0; m_ti = 0; m_tick = 0; m_ip_hw = 0; m_ip_sw = 0; m_exc = 0;
  endtask

  // Apply one clock edge's worth of architectural effects using pre-edge state and inputs.
  task automatic model_update();
    logic intp, take, eret, wr, old_ti, old_tick;
    logic [31:0] old_count, old_compare;
    logic [4:0] code;
    if (!rst) begin
      model_reset();
      return;
    end
    intp = m_int_pending();
    take = MEM_valid && (intp || MEM_Exception);
    eret = MEM_valid && !take && MEM_eret_flush;
    wr = MEM_valid && MEM_CP0WrEn && !take && !eret;
    code = intp ? 5'd0 : MEM_ExcCode;
    old_ti = m_ti; old_tick = m_tick; old_count = m_count; old_compare = m_compare;
    m_tick = !old_tick;
    if (old_tick) m_count = old_count + 1;
    if (old_count == old_compare && old_compare != 0) m_ti = 1'b1;
    m_ip_hw = {ext_int[5] | old_ti, ext_int[4:0]};
    if (take) begin
      if (!m_exl) begin
        m_epc = MEM_isBD ? MEM_PC - 4 : MEM_PC;
        m_bd = MEM_isBD;
      end
      m_exl = 1'b1;
      m_exc = code;
      if (code == 5'd4 || code == 5'd5) m_badv = badvaddr;
    end
    if (eret) m_exl = 1'b0;
    if (wr) begin
      case (MEM_CP0Addr)
        8'h48: m_count = MEM_GPR_RT;
        8'h58: begin m_compare = MEM_GPR_RT; m_ti = 1'b0; end
        8'h60: begin m_im = MEM_GPR_RT[15:8]; m_exl = MEM_GPR_RT[1]; m_ie = MEM_GPR_RT[0]; end
        8'h68: m_ip_sw = MEM_GPR_RT[9:8];
        8'h70: m_epc = MEM_GPR_RT;
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_idle();
    MEM_valid = 0; MEM_Exception = 0; MEM_ExcCode = 0; MEM_isBD = 0; MEM_PC = 0;
    badvaddr = 0; MEM_eret_flush = 0; MEM_CP0WrEn = 0; MEM_CP0Addr = 0; MEM_GPR_RT = 0;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    set_idle();
    MEM_valid = 1; MEM_CP0WrEn = 1; MEM_CP0Addr = a; MEM_GPR_RT = d;
    step();
  endtask

  task automatic do_reset();
    set_idle();
    ext_int = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    set_idle();
    ext_int = 0;
    MEM_valid = 1; MEM_Exception = 1;
    rst = 0;
    model_reset();
    #3;
    checks++;
    if (flush !== 1'b0) begin
      errors++; $display("FAIL reset_flush: got %b expected 0", flush);
    end
    @(negedge clk);
    set_idle();
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (flush !== 1'b0) begin
        errors++; $display("FAIL idle_flush cyc %0d: got %b expected 0", i, flush);
      end
      step();
    end
    MEM_CP0Addr = 8'h48; #1;
    checks++;
    if (CP0Out !== 32'd5) begin
      errors++; $display("FAIL idle_count: got %h expected 00000005", CP0Out);
    end
    MEM_CP0Addr = 8'h60; #1;
    checks++;
    if (CP0Out !== 32'h0040_0000) begin
      errors++; $display("FAIL reset_status: got %h expected 00400000", CP0Out);
    end
  endtask

  task automatic test_exception();
    set_idle();
    MEM_valid = 1; MEM_Exception = 1; MEM_ExcCode = 5'd4; MEM_PC = 32'h8000_0104;
    MEM_isBD = 1; badvaddr = 32'h8000_0003;
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_pc !== ExcVector) begin
      errors++; $display("FAIL exc_flush: got %b/%h expected 1/%h", flush, redirect_pc, ExcVector);
    end
    step();
    set_idle();
    MEM_CP0Addr = 8'h70; #1;
    checks++;
    if (CP0Out !== 32'h8000_0100 || EPC_out !== 32'h8000_0100) begin
      errors++; $display("FAIL exc_epc: got %h/%h expected 80000100", CP0Out, EPC_out);
    end
    MEM_CP0Addr = 8'h68; #1;
    checks++;
    if (CP0Out !== 32'h8000_0010) begin
      errors++; $display("FAIL exc_cause: got %h expected 80000010", CP0Out);
    end
    MEM_CP0Addr = 8'h40; #1;
    checks++;
    if (CP0Out !== 32'h8000_0003) begin
      errors++; $display("FAIL exc_badvaddr: got %h expected 80000003", CP0Out);
    end
    MEM_CP0Addr = 8'h60; #1;
    checks++;
    if (CP0Out !== 32'h0040_0002) begin
      errors++; $display("FAIL exc_status: got %h expected 00400002", CP0Out);
    end
  endtask

  task automatic test_nested();
    set_idle();
    MEM_valid = 1; MEM_Exception = 1; MEM_ExcCode = 5'd10; MEM_PC = 32'h8000_0200;
    badvaddr = 32'h0000_DEAD;
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_pc !== ExcVector) begin
      errors++; $display("FAIL nest_flush: got %b/%h expected 1/%h", flush, redirect_pc, ExcVector);
    end
    step();
    set_idle();
    MEM_CP0Addr = 8'h70; #1;
    checks++;
    if (CP0Out !== 32'h8000_0100) begin
      errors++; $display("FAIL nest_epc: got %h expected 80000100", CP0Out);
    end
    MEM_CP0Addr = 8'h68; #1;
    checks++;
    if (CP0Out !== 32'h8000_0028) begin
      errors++; $display("FAIL nest_cause: got %h expected 80000028", CP0Out);
    end
    MEM_CP0Addr = 8'h40; #1;
    checks++;
    if (CP0Out !== 32'h8000_0003) begin
      errors++; $display("FAIL nest_badvaddr: got %h expected 80000003", CP0Out);
    end
    set_idle();
    MEM_valid = 1; MEM_eret_flush = 1;
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_pc !== 32'h8000_0100) begin
      errors++; $display("FAIL eret_redirect: got %b/%h expected 1/80000100", flush, redirect_pc);
    end
    step();
    set_idle();
    MEM_CP0Addr = 8'h60; #1;
    checks++;
    if (CP0Out !== 32'h0040_0000) begin
      errors++; $display("FAIL eret_status: got %h expected 00400000", CP0Out);
    end
    // Exception and ERET together: the exception is taken.
    set_idle();
    MEM_valid = 1; MEM_Exception = 1; MEM_ExcCode = 5'd12; MEM_eret_flush = 1;
    MEM_PC = 32'h8000_0400;
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_pc !== ExcVector) begin
      errors++; $display("FAIL exc_eret_prio: got %b/%h expected 1/%h", flush, redirect_pc, ExcVector);
    end
    step();
    set_idle();
    MEM_CP0Addr = 8'h68; #1;
    checks++;
    if (CP0Out !== 32'h0000_0030 || EPC_out !== 32'h8000_0400) begin
      errors++; $display("FAIL exc_eret_state: got %h/%h expected 00000030/80000400", CP0Out, EPC_out);
    end
  endtask

  task automatic test_timer();
    logic found;
    do_reset();
    mtc0(8'h60, 32'h0040_8001);
    mtc0(8'h58, 32'd6);
    set_idle();
    MEM_valid = 1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (flush !== m_flush()) begin
        errors++; $display("FAIL timer_wait cyc %0d: got %b expected %b", i, flush, m_flush());
      end
      if (flush === 1'b1) begin
        found = 1;
        break;
      end
      step();
    end
    checks++;
    if (!found || redirect_pc !== ExcVector) begin
      errors++; $display("FAIL timer_irq: got found=%b pc=%h expected 1/%h", found, redirect_pc, ExcVector);
    end
    step();
    set_idle();
    MEM_CP0Addr = 8'h68; #1;
    checks++;
    if (CP0Out !== 32'h4000_8000) begin
      errors++; $display("FAIL timer_cause: got %h expected 40008000", CP0Out);
    end
    mtc0(8'h58, 32'h100);
    set_idle();
    MEM_CP0Addr = 8'h68; #1;
    checks++;
    if (CP0Out !== 32'h0000_8000) begin
      errors++; $display("FAIL timer_ti_clr: got %h expected 00008000", CP0Out);
    end
    step();
    checks++;
    if (CP0Out !== 32'h0000_0000) begin
      errors++; $display("FAIL timer_ip7_clr: got %h expected 00000000", CP0Out);
    end
  endtask

  task automatic test_ext_int_bubble();
    do_reset();
    ext_int = 6'b000001;
    mtc0(8'h60, 32'h0040_0401);
    set_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (flush !== 1'b0) begin
        errors++; $display("FAIL bubble_flush cyc %0d: got %b expected 0", i, flush);
      end
      step();
    end
    MEM_valid = 1; MEM_PC = 32'h8000_0300;
    #1;
    checks++;
    if (flush !== 1'b1 || redirect_pc !== ExcVector) begin
      errors++; $display("FAIL ext_irq: got %b/%h expected 1/%h", flush, redirect_pc, ExcVector);
    end
    step();
    set_idle();
    ext_int = 0;
    MEM_CP0Addr = 8'h68; #1;
    checks++;
    if (EPC_out !== 32'h8000_0300 || CP0Out[6:2] !== 5'd0) begin
      errors++; $display("FAIL ext_state: got epc=%h code=%0d expected 80000300/0", EPC_out, CP0Out[6:2]);
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    mtc0(8'h48, 32'hFFFF_FFFF);
    set_idle();
    MEM_CP0Addr = 8'h48; #1;
    checks++;
    if (CP0Out !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL count_write: got %h expected ffffffff", CP0Out);
    end
    step();
    checks++;
    if (CP0Out !== 32'd0) begin
      errors++; $display("FAIL count_wrap: got %h expected 00000000", CP0Out);
    end
    step();
    mtc0(8'h48, 32'h1234);
    set_idle();
    MEM_CP0Addr = 8'h48; #1;
    checks++;
    if (CP0Out !== 32'h1234) begin
      errors++; $display("FAIL count_write_wins: got %h expected 00001234", CP0Out);
    end
    set_idle();
    MEM_valid = 1; MEM_Exception = 1; MEM_ExcCode = 5'd12;
    MEM_CP0WrEn = 1; MEM_CP0Addr = 8'h58; MEM_GPR_RT = 32'h55;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      errors++; $display("FAIL mtc0_exc_flush: got %b expected 1", flush);
    end
    step();
    set_idle();
    MEM_CP0Addr = 8'h58; #1;
    checks++;
    if (CP0Out !== 32'd0) begin
      errors++; $display("FAIL mtc0_suppressed: got %h expected 00000000", CP0Out);
    end
  endtask

  task automatic test_random();
    logic [7:0] addrs [7];
    addrs = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h00};
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      MEM_valid = ($urandom_range(0, 3) != 0);
      MEM_Exception = ($urandom_range(0, 9) == 0);
      MEM_ExcCode = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom());
      MEM_isBD = 1'($urandom());
      MEM_PC = $urandom() & 32'hFFFF_FFFC;
      badvaddr = $urandom();
      MEM_eret_flush = ($urandom_range(0, 7) == 0);
      MEM_CP0WrEn = ($urandom_range(0, 2) == 0);
      MEM_CP0Addr = addrs[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) MEM_CP0Addr = 8'($urandom());
      MEM_GPR_RT = $urandom();
      if (MEM_CP0Addr == 8'h58) MEM_GPR_RT = m_count + $urandom_range(0, 15);
      if ($urandom_range(0, 31) == 0) ext_int = 6'($urandom());
      #1;
      checks++;
      if (flush !== m_flush()) begin
        errors++; $display("FAIL rand_flush cyc %0d: got %b expected %b", cyc, flush, m_flush());
      end
      if (m_flush()) begin
        checks++;
        if (redirect_pc !== m_redirect()) begin
          errors++;
          $display("FAIL rand_redirect cyc %0d: got %h expected %h", cyc, redirect_pc, m_redirect());
        end
      end
      checks++;
      if (CP0Out !== m_read(MEM_CP0Addr)) begin
        errors++;
        $display("FAIL rand_cp0out cyc %0d addr %h: got %h expected %h", cyc, MEM_CP0Addr, CP0Out,
                 m_read(MEM_CP0Addr));
      end
      checks++;
      if (EPC_out !== m_epc) begin
        errors++; $display("FAIL rand_epc cyc %0d: got %h expected %h", cyc, EPC_out, m_epc);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    mtc0(8'h70, 32'hCAFE_0000);
    mtc0(8'h60, 32'h0000_0303);
    set_idle();
    MEM_CP0Addr = 8'h60; #1;
    checks++;
    if (EPC_out !== 32'hCAFE_0000 || CP0Out !== 32'h0040_0303) begin
      errors++; $display("FAIL pre_areset: got %h/%h expected cafe0000/00400303", EPC_out, CP0Out);
    end
    MEM_valid = 1; MEM_Exception = 1;
    #2;
    rst = 0;
    #1;
    checks++;
    if (flush !== 1'b0 || CP0Out !== 32'h0040_0000 || EPC_out !== 32'd0) begin
      errors++;
      $display("FAIL areset: got flush=%b status=%h epc=%h expected 0/00400000/00000000",
               flush, CP0Out, EPC_out);
    end
    model_reset();
    set_idle();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    test_reset();
    test_exception();
    test_nested();
    test_timer();
    test_ext_int_bubble();
    test_count_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
